// File: rtl/sonar_ranger.sv
// HC-SR04 style ultrasonic ranger: trigger pulse, echo timing, prescaled cm conversion, angle tagging.
// Optional SONAR_AVG_EN: report the running mean of the last four non-timeout results.
module sonar_ranger #(
  parameter int TRIG_CYCLES    = 270,
  parameter int TICKS_PER_CM   = 1566,
  parameter int MAX_CM         = 400,
  parameter int TIMEOUT_CYCLES = 675000,
  parameter int HOLDOFF_CYCLES = 1620000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] angle,
  input  logic       echo,
  output logic       trig,
  output logic       busy,
  output logic [8:0] dist_cm,
  output logic [7:0] dist_angle,
  output logic       valid,
  output logic       timeout
);

  localparam int CNT_MAX0 = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > HOLDOFF_CYCLES) ? CNT_MAX0 : HOLDOFF_CYCLES;
  localparam int CW       = $clog2(CNT_MAX);
  localparam int PW       = $clog2(TICKS_PER_CM);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_DONE, S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [8:0]    cm_q, cm_d, cm_inc_s;
  logic [7:0]    angle_q, angle_d;
  logic [2:0]    echo_q;
  logic          echo_rise_s, echo_fall_s;
  logic          done_s, res_to_s;
  logic [8:0]    res_cm_s;
  logic          trig_q, trig_d, busy_q, busy_d, valid_q, valid_d, to_q, to_d;
  logic [8:0]    dist_q, dist_d;
  logic [7:0]    dang_q, dang_d;
`ifdef SONAR_AVG_EN
  logic [8:0]    hist_q [4];
  logic [8:0]    hist_d [4];
  logic [2:0]    nh_q, nh_d;
  logic [10:0]   sum_q, sum_d;
  logic [9:0]    pair_s;
  logic [8:0]    avg_s;
`endif

  // echo_q[1] is the synchronised echo, echo_q[2] its previous value for edge detection
  assign echo_rise_s = echo_q[1] & ~echo_q[2];
  assign echo_fall_s = ~echo_q[1] & echo_q[2];

  // FSM next state, counters and measurement result
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    psc_d    = psc_q;
    cm_d     = cm_q;
    angle_d  = angle_q;
    done_s   = 1'b0;
    res_cm_s = 9'd0;
    res_to_s = 1'b0;
    cm_inc_s = (cm_q < 9'(MAX_CM)) ? cm_q + 9'd1 : cm_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          angle_d = angle;
          state_d = S_TRIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_TRIG;
        end
      end
      S_WAIT: begin
        if (echo_rise_s) begin
          cnt_d   = '0;
          psc_d   = '0;
          cm_d    = 9'd0;
          state_d = S_MEAS;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          res_cm_s = 9'(MAX_CM);
          res_to_s = 1'b1;
          done_s   = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_MEAS: begin
        if (psc_q == PW'(TICKS_PER_CM - 1)) begin
          psc_d = '0;
          cm_d  = cm_inc_s;
        end else begin
          psc_d = psc_q + PW'(1);
        end
        // This cycle's tick counts, and timeout/saturation outranks a coincident fall
        if ((cnt_q == CW'(TIMEOUT_CYCLES - 1)) || (cm_d == 9'(MAX_CM))) begin
          res_cm_s = 9'(MAX_CM);
          res_to_s = 1'b1;
          done_s   = 1'b1;
          state_d  = S_DONE;
        end else if (echo_fall_s) begin
          res_cm_s = cm_d;
          res_to_s = 1'b0;
          done_s   = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_MEAS;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output registers, and the optional averaging history
  always_comb begin
    trig_d  = (state_d == S_TRIG);
    busy_d  = (state_d != S_IDLE);
    valid_d = done_s;
    dist_d  = dist_q;
    dang_d  = dang_q;
    to_d    = to_q;
`ifdef SONAR_AVG_EN
    hist_d = hist_q;
    nh_d   = nh_q;
    sum_d  = sum_q;
    pair_s = {1'b0, res_cm_s} + {1'b0, hist_q[0]};
    avg_s  = res_cm_s;
    if (done_s && !res_to_s) begin
      hist_d[0] = res_cm_s;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
      sum_d = sum_q + {2'b00, res_cm_s} - ((nh_q == 3'd4) ? {2'b00, hist_q[3]} : 11'd0);
      nh_d  = (nh_q == 3'd4) ? 3'd4 : nh_q + 3'd1;
      // Three samples use only the newest two so the divide stays a shift
      case (nh_d)
        3'd1:       avg_s = res_cm_s;
        3'd2, 3'd3: avg_s = 9'(pair_s >> 1);
        3'd4:       avg_s = 9'(sum_d >> 2);
        default:    avg_s = res_cm_s;
      endcase
    end else begin
      avg_s = res_cm_s;
    end
`endif
    if (done_s) begin
      dang_d = angle_q;
      to_d   = res_to_s;
`ifdef SONAR_AVG_EN
      dist_d = res_to_s ? 9'(MAX_CM) : avg_s;
`else
      dist_d = res_cm_s;
`endif
    end else begin
      dist_d = dist_q;
    end
  end

  // State, counters, echo synchroniser and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      psc_q   <= '0;
      cm_q    <= 9'd0;
      angle_q <= 8'd0;
      echo_q  <= 3'd0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      dist_q  <= 9'd0;
      dang_q  <= 8'd0;
`ifdef SONAR_AVG_EN
      for (int i = 0; i < 4; i++) hist_q[i] <= 9'd0;
      nh_q  <= 3'd0;
      sum_q <= 11'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
      cm_q    <= cm_d;
      angle_q <= angle_d;
      echo_q  <= {echo_q[1:0], echo};
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      dist_q  <= dist_d;
      dang_q  <= dang_d;
`ifdef SONAR_AVG_EN
      hist_q <= hist_d;
      nh_q   <= nh_d;
      sum_q  <= sum_d;
`endif
    end
  end

  assign trig       = trig_q;
  assign busy       = busy_q;
  assign valid      = valid_q;
  assign timeout    = to_q;
  assign dist_cm    = dist_q;
  assign dist_angle = dang_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Bench for sonar_ranger: two instances (MAX_CM 400 and 20) on shared stimulus, checked against
// an arithmetic model of width->cm, saturation, timeouts, holdoff and reset behaviour.
module tb_sonar_ranger;
  localparam int TRIG = 4;
  localparam int TICKS = 10;
  localparam int TMO = 1000;
  localparam int HOLD = 20;
  localparam int MAXC [2] = '{400, 20};

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic echo = 1'b0;
  logic [7:0] angle = 8'd0;
  logic trig_w [2];
  logic busy_w [2];
  logic valid_w [2];
  logic to_w [2];
  logic [8:0] dist_w [2];
  logic [7:0] ang_w [2];
  int n_cmp = 0;
  int n_err = 0;
`ifdef SONAR_AVG_EN
  int hist [2][$];
`endif

  always #5 clk = ~clk;

  sonar_ranger #(.TRIG_CYCLES(TRIG), .TICKS_PER_CM(TICKS), .MAX_CM(400),
                 .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .angle(angle), .echo(echo),
    .trig(trig_w[0]), .busy(busy_w[0]), .dist_cm(dist_w[0]), .dist_angle(ang_w[0]),
    .valid(valid_w[0]), .timeout(to_w[0]));

  sonar_ranger #(.TRIG_CYCLES(TRIG), .TICKS_PER_CM(TICKS), .MAX_CM(20),
                 .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD)) u_sat (
    .clk(clk), .nrst(nrst), .start(start), .angle(angle), .echo(echo),
    .trig(trig_w[1]), .busy(busy_w[1]), .dist_cm(dist_w[1]), .dist_angle(ang_w[1]),
    .valid(valid_w[1]), .timeout(to_w[1]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

`ifdef SONAR_AVG_EN
  task automatic model_avg(input int k, input int raw, output int o);
    int s;
    hist[k].push_front(raw);
    if (hist[k].size() > 4) void'(hist[k].pop_back());
    s = 0;
    foreach (hist[k][i]) s += hist[k][i];
    if (hist[k].size() == 1) o = raw;
    else if (hist[k].size() < 4) o = (hist[k][0] + hist[k][1]) / 2;
    else o = s / 4;
  endtask
`endif

  // One measurement: t counts samples from the first cycle after trig falls
  task automatic run_meas(input logic [7:0] ang, input int d, input int w, input bit no_echo,
                          input bit pre_high, input bit keep_start, input logic [7:0] ang2);
    int tlen, t, lim, ed, avg;
    int exp_d [2];
    int exp_to [2];
    int exp_tv [2];
    int nv [2];
    int tv [2];
    int tidle [2];
    logic [8:0] gd [2];
    logic [7:0] ga [2];
    logic gt [2];
    for (int k = 0; k < 2; k++) begin
      if (no_echo) begin
        exp_to[k] = 1; exp_d[k] = MAXC[k]; exp_tv[k] = TMO;
      end else begin
        lim = (TMO < TICKS * MAXC[k]) ? TMO : TICKS * MAXC[k];
        if (w >= lim) begin
          exp_to[k] = 1; exp_d[k] = MAXC[k]; exp_tv[k] = d + lim + 3;
        end else begin
          ed = w / TICKS;
`ifdef SONAR_AVG_EN
          model_avg(k, ed, avg);
          ed = avg;
`endif
          exp_to[k] = 0; exp_d[k] = ed; exp_tv[k] = d + w + 3;
        end
      end
      nv[k] = 0; tv[k] = 0; tidle[k] = -1; gd[k] = 9'd0; ga[k] = 8'd0; gt[k] = 1'b0;
    end
    angle = ang;
    start = 1'b1;
    echo = pre_high;
    tick;
    start = keep_start;
    tlen = 0;
    while (trig_w[0] && tlen < 50) begin
      tlen++;
      tick;
    end
    chk("trig_len", tlen, TRIG);
    t = 0;
    while ((tidle[0] < 0 || tidle[1] < 0) && t < 3000) begin
      t++;
      if (pre_high) echo = (t < 3) || (t >= d && t < d + w);
      else echo = !no_echo && t >= d && t < d + w;
      if (t == d + 3) angle = ang2;
      tick;
      for (int k = 0; k < 2; k++) begin
        if (valid_w[k]) begin
          nv[k]++; tv[k] = t; gd[k] = dist_w[k]; ga[k] = ang_w[k]; gt[k] = to_w[k];
        end
        if (!busy_w[k] && tidle[k] < 0) tidle[k] = t;
      end
    end
    echo = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid_count%0d", k), nv[k], 1);
      chk($sformatf("dist%0d", k), gd[k], exp_d[k]);
      chk($sformatf("angle%0d", k), ga[k], ang);
      chk($sformatf("timeout%0d", k), gt[k], exp_to[k]);
      chk_rng($sformatf("latency%0d", k), tv[k], exp_tv[k] - 1, exp_tv[k] + 1);
      chk($sformatf("holdoff%0d", k), tidle[k] - tv[k], HOLD + 1);
      chk($sformatf("dist_hold%0d", k), dist_w[k], exp_d[k]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_trig%0d", tag, k), trig_w[k], 0);
      chk($sformatf("%s_busy%0d", tag, k), busy_w[k], 0);
      chk($sformatf("%s_valid%0d", tag, k), valid_w[k], 0);
      chk($sformatf("%s_dist%0d", tag, k), dist_w[k], 0);
      chk($sformatf("%s_to%0d", tag, k), to_w[k], 0);
    end
  endtask

  task automatic quiet_after_reset(input string tag);
    int nv, nb, n;
    nv = 0; nb = 0; n = 0;
    #2 nrst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      for (int k = 0; k < 2; k++) begin
        if (valid_w[k]) nv++;
        if (busy_w[k]) nb++;
      end
    end
    chk({tag, "_no_valid"}, nv, n);
    chk({tag, "_no_busy"}, nb, n);
  endtask

  initial begin
    int r, d, w, ng;
    bit ne;
    logic [7:0] a;
    #1;
    check_reset_outputs("rst0");
    for (int k = 0; k < 2; k++) chk($sformatf("rst0_ang%0d", k), ang_w[k], 0);
    #2 nrst = 1'b1;
    repeat (3) tick;

    run_meas(8'd100, 30, 253, 1'b0, 1'b0, 1'b0, 8'd100);
    run_meas(8'd110, 1, 0, 1'b1, 1'b0, 1'b0, 8'd110);
    run_meas(8'd120, 10, 500, 1'b0, 1'b0, 1'b0, 8'd120);
    run_meas(8'd100, 20, 100, 1'b0, 1'b0, 1'b1, 8'd150);
    run_meas(8'd150, 20, 120, 1'b0, 1'b0, 1'b0, 8'd150);
    run_meas(8'd130, 13, 55, 1'b0, 1'b1, 1'b0, 8'd130);
    run_meas(8'd61, 5, 199, 1'b0, 1'b0, 1'b0, 8'd61);
    run_meas(8'd62, 5, 200, 1'b0, 1'b0, 1'b0, 8'd62);
    run_meas(8'd63, 5, 999, 1'b0, 1'b0, 1'b0, 8'd63);
    run_meas(8'd64, 5, 1000, 1'b0, 1'b0, 1'b0, 8'd64);

    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(60, 231));
      d = $urandom_range(1, 400);
      r = $urandom_range(0, 9);
      ne = (r == 0);
      if (r <= 2) w = $urandom_range(150, 260);
      else if (r == 3) w = $urandom_range(990, 1010);
      else w = $urandom_range(1, 989);
      run_meas(a, d, w, ne, 1'b0, 1'b0, a);
    end

    // Reset during TRIG
    angle = 8'd77;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("pre_rst_trig", trig_w[0], 1);
    #2 nrst = 1'b0;
    #1 check_reset_outputs("rst_trig");
    quiet_after_reset("rst_trig");

    // Reset during MEASURE
    angle = 8'd90;
    start = 1'b1;
    tick;
    start = 1'b0;
    ng = 0;
    while (trig_w[0] && ng < 50) begin
      ng++;
      tick;
    end
    echo = 1'b1;
    repeat (60) tick;
    chk("pre_rst_busy", busy_w[0], 1);
    #2 nrst = 1'b0;
    #1 check_reset_outputs("rst_meas");
    echo = 1'b0;
    quiet_after_reset("rst_meas");
`ifdef SONAR_AVG_EN
    hist[0].delete();
    hist[1].delete();
`endif
    run_meas(8'd200, 30, 253, 1'b0, 1'b0, 1'b0, 8'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
